hamming_ecc_reader: RTL and testbench
=====================================

HAMMING_ECC_READER -- requirements
Module: hamming_ecc_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, giving the memory address width (2^ADDR_W codewords).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid_i  input  1  read request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 SHALL have port req_addr_i  input  ADDR_W  word address to read.
REQ-007 SHALL have port mem_rd_en_o  output  1  memory read strobe; mem_rdata_i is valid exactly one cycle later.
REQ-008 SHALL have port mem_wr_en_o  output  1  scrub write-back strobe.
REQ-009 SHALL have port mem_addr_o  output  ADDR_W  memory address for read and scrub.
REQ-010 SHALL have port mem_wdata_o  output  12  corrected codeword for scrub.
REQ-011 SHALL have port mem_rdata_i  input  12  stored Hamming(12,8) codeword.
REQ-012 SHALL have port rsp_valid_o  output  1  response valid.
REQ-013 SHALL have port rsp_ready_i  input  1  response consumer ready.
REQ-014 SHALL have port rsp_data_o  output  8  decoded, corrected data byte.
REQ-015 SHALL have port rsp_corr_o  output  1  a single-bit error was corrected.
REQ-016 SHALL have port rsp_bad_o  output  1  syndrome 13..15, which is uncorrectable.
REQ-017 SHALL have port err_count_o  output  8  count of corrected words, saturating.

Function
REQ-018 Codeword layout SHALL be: code bit k = position k+1; parity bits at positions 1, 2, 4 and 8 (bits 0, 1, 3, 7); data[7:0] at positions 3, 5, 6, 7, 9, 10, 11, 12 (bits 2, 4, 5, 6, 8, 9, 10, 11), MSB first; even parity.
REQ-019 Syndrome SHALL be {s8,s4,s2,s1}, where each s is the XOR of every code bit whose position has that weight bit set.
REQ-020 The FSM SHALL have the states IDLE, READ, CHECK, SCRUB and RESP.
REQ-021 req_ready_o SHALL be 1 only in IDLE; on the req_valid_i & req_ready_o edge, SHALL latch req_addr_i and go to READ.
REQ-022 READ SHALL last exactly 1 cycle: mem_rd_en_o=1, mem_addr_o=latched address, next state CHECK.
REQ-023 CHECK SHALL last 1 cycle: sample mem_rdata_i, compute the syndrome, and register data, corrected codeword and flags.
REQ-024 CHECK decision: syndrome 0 -> RESP with flags 0; syndrome 1..12 -> flip code bit (syndrome-1), set rsp_corr_o, go to SCRUB; syndrome 13..15 -> set rsp_bad_o, no flip, extract raw data, go to RESP.
REQ-025 SCRUB SHALL last exactly 1 cycle: mem_wr_en_o=1, mem_addr_o=latched address, mem_wdata_o=corrected codeword, next state RESP.
REQ-026 err_count_o SHALL increment by 1 on each CHECK->SCRUB transition and saturate at 255.
REQ-027 RESP SHALL hold rsp_valid_o=1 with rsp_data_o, rsp_corr_o and rsp_bad_o stable until rsp_ready_i=1, then go to IDLE on that edge.
REQ-028 Response latency SHALL be: rsp_valid_o high 3 edges after the accepting edge for a clean or bad word, and 4 edges after it for a corrected word.
REQ-029 mem_rd_en_o and mem_wr_en_o SHALL never be high in the same cycle; outside READ and SCRUB both SHALL be 0.
REQ-030 New requests SHALL NOT be accepted while busy; only one transaction SHALL be in flight.

Reset
REQ-031 While rst_i=1, regardless of clock, outputs SHALL be: state IDLE, req_ready_o=0, all strobes 0, rsp_valid_o=0, rsp_data_o=0, flags 0, err_count_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-032 req_ready_o SHALL assert on the first clock edge after rst_i deasserts.
REQ-033 Reset asserted in any state, including SCRUB, SHALL drop mem_wr_en_o immediately and abort the transaction with no response.

Verification
REQ-034 Clean read: memory holds 12'hC6A -> rsp_data_o=8'h33, corr=0, bad=0, no write strobe, err_count_o unchanged.
REQ-035 Single-bit error: memory holds 12'hC4A (bit 5 flipped) -> syndrome 6, rsp_data_o=8'h33, corr=1, scrub write of 12'hC6A to the same address, err_count_o+1.
REQ-036 Uncorrectable: memory holds 12'h46B (bits 0 and 11 flipped) -> syndrome 13, bad=1, corr=0, no scrub, err_count_o unchanged.
REQ-037 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data held stable, req_ready_o=0 throughout; new request accepted only after the handshake.
REQ-038 Reset mid-SCRUB: rst_i pulsed during SCRUB -> mem_wr_en_o=0 at once, no rsp_valid_o, err_count_o=0.
REQ-039 Saturation: 260 corrected reads -> err_count_o=255.

Source files
------------

// File: rtl/hamming_ecc_reader.sv
`timescale 1ns/1ps
// hamming_ecc_reader: single-outstanding read port over a Hamming(12,8)
// protected memory. Each read is checked, single-bit errors are corrected
// and scrubbed back to memory, and uncorrectable syndromes are flagged.
module hamming_ecc_reader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [11:0]       mem_wdata_o,
  input  logic [11:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_data_o,
  output logic              rsp_corr_o,
  output logic              rsp_bad_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    SCRUB,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [11:0]         code_q, code_d;
  logic [7:0]          data_q, data_d;
  logic                corr_q, corr_d;
  logic                bad_q, bad_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [3:0]          syn;
  logic [11:0]         flip;
  logic [11:0]         fixed;

  // Data bits sit at code bits 2,4,5,6,8,9,10,11 with data[7] at bit 2.
  function automatic logic [7:0] extract(input logic [11:0] c);
    return {c[2], c[4], c[5], c[6], c[8], c[9], c[10], c[11]};
  endfunction

  // Syndrome of the word returned by memory; each mask selects the code
  // bits whose 1-based position has the corresponding weight bit set.
  always_comb begin
    syn[0] = ^(mem_rdata_i & 12'h555);
    syn[1] = ^(mem_rdata_i & 12'h666);
    syn[2] = ^(mem_rdata_i & 12'h878);
    syn[3] = ^(mem_rdata_i & 12'hF80);
    flip   = 12'd1 << (syn - 4'd1);
    fixed  = mem_rdata_i ^ flip;
  end

  // Next-state and datapath update for the read/check/scrub/respond sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    code_d  = code_q;
    data_d  = data_q;
    corr_d  = corr_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          addr_d  = req_addr_i;
          state_d = READ;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        if (syn == 4'd0) begin
          code_d  = mem_rdata_i;
          data_d  = extract(mem_rdata_i);
          corr_d  = 1'b0;
          bad_d   = 1'b0;
          state_d = RESP;
        end else if (syn <= 4'd12) begin
          code_d  = fixed;
          data_d  = extract(fixed);
          corr_d  = 1'b1;
          bad_d   = 1'b0;
          state_d = SCRUB;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          code_d  = mem_rdata_i;
          data_d  = extract(mem_rdata_i);
          corr_d  = 1'b0;
          bad_d   = 1'b1;
          state_d = RESP;
        end
      end
      SCRUB: state_d = RESP;
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low while reset is held and rises on
    // the first edge after release, yet still tracks the IDLE state exactly.
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      code_q  <= '0;
      data_q  <= '0;
      corr_q  <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      data_q  <= data_d;
      corr_q  <= corr_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = ready_q;
  assign mem_rd_en_o = (state_q == READ);
  assign mem_wr_en_o = (state_q == SCRUB);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = code_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = data_q;
  assign rsp_corr_o  = corr_q;
  assign rsp_bad_o   = bad_q;
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_hamming_ecc_reader.sv
`timescale 1ns/1ps
// Directed bench for hamming_ecc_reader with a one-cycle-latency memory model.
module tb_hamming_ecc_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_corr;
  logic        rsp_bad;
  logic [7:0]  err_count;

  logic [11:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [11:0] pre_data = '0;
  logic        collide = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  hamming_ecc_reader #(.ADDR_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .mem_rd_en_o (mem_rd_en),
    .mem_wr_en_o (mem_wr_en),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_corr_o  (rsp_corr),
    .rsp_bad_o   (rsp_bad),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  // Memory: read data one cycle after the strobe; scrub and bench preload writes.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) collide = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input logic [3:0] a, input logic [11:0] w);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = w;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Accept counts as edge 1; lat is the edge count at which rsp_valid is seen.
  task automatic do_read(input logic [3:0] a, output logic [7:0] data,
                         output logic corr, output logic bad, output int lat,
                         output logic wrote, output logic [3:0] waddr,
                         output logic [11:0] wdata);
    int guard;
    wrote = 1'b0; waddr = '0; wdata = '0; data = '0; corr = 1'b0; bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 20), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      if (mem_wr_en) begin
        wrote = 1'b1; waddr = mem_addr; wdata = mem_wdata;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    data = rsp_data; corr = rsp_corr; bad = rsp_bad;
    @(posedge clk);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [11:0] w;
    logic [7:0]  d;
    logic        c;
    logic        b;
    logic [11:0] s;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  d;
    logic        c, b, wr;
    logic [3:0]  wa;
    logic [11:0] wd;
    int          lat;
    int          exp_err;
    int          guard;
    logic        saw_valid;

    // addr, stored word, data, corr, bad, scrubbed word
    vecs[0] = '{4'd3,  12'hC6A, 8'h33, 1'b0, 1'b0, 12'h000}; // clean
    vecs[1] = '{4'd5,  12'hC4A, 8'h33, 1'b1, 1'b0, 12'hC6A}; // syndrome 6
    vecs[2] = '{4'd7,  12'h46B, 8'h32, 1'b0, 1'b1, 12'h000}; // syndrome 13
    vecs[3] = '{4'd8,  12'hCEA, 8'h33, 1'b1, 1'b0, 12'hC6A}; // syndrome 8
    vecs[4] = '{4'd10, 12'h46A, 8'h33, 1'b1, 1'b0, 12'hC6A}; // syndrome 12
    vecs[5] = '{4'd11, 12'hC6B, 8'h33, 1'b1, 1'b0, 12'hC6A}; // syndrome 1
    vecs[6] = '{4'd12, 12'h46E, 8'hB2, 1'b0, 1'b1, 12'h000}; // syndrome 15
    vecs[7] = '{4'd13, 12'h468, 8'h32, 1'b0, 1'b1, 12'h000}; // syndrome 14
    vecs[8] = '{4'd0,  12'h000, 8'h00, 1'b0, 1'b0, 12'h000}; // all zero
    vecs[9] = '{4'd15, 12'hFFF, 8'hFE, 1'b1, 1'b0, 12'h7FF}; // syndrome 12

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_flags", 32'({rsp_corr, rsp_bad}), 32'd0);
    check("rst_err",   32'(err_count), 32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_first_edge", 32'(req_ready), 32'd1);

    // Directed vector table
    exp_err = 0;
    for (int i = 0; i < 10; i++) preload(vecs[i].a, vecs[i].w);
    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].a, d, c, b, lat, wr, wa, wd);
      if (vecs[i].c) exp_err++;
      check($sformatf("v%0d_data", i),  32'(d),   32'(vecs[i].d));
      check($sformatf("v%0d_corr", i),  32'(c),   32'(vecs[i].c));
      check($sformatf("v%0d_bad", i),   32'(b),   32'(vecs[i].b));
      check($sformatf("v%0d_lat", i),   32'(lat), vecs[i].c ? 32'd4 : 32'd3);
      check($sformatf("v%0d_wrote", i), 32'(wr),  32'(vecs[i].c));
      check($sformatf("v%0d_waddr", i), 32'(wa),  vecs[i].c ? 32'(vecs[i].a) : 32'd0);
      check($sformatf("v%0d_wdata", i), 32'(wd),  vecs[i].c ? 32'(vecs[i].s) : 32'd0);
      check($sformatf("v%0d_mem", i),   32'(mem[vecs[i].a]),
            vecs[i].c ? 32'(vecs[i].s) : 32'(vecs[i].w));
      check($sformatf("v%0d_err", i),   32'(err_count), 32'(exp_err));
    end

    // Backpressure: response held while a second request waits
    preload(4'd2, 12'hC6A);
    preload(4'd9, 12'hC4A);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 4'd2; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_addr = 4'd9;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    check("bp_valid_seen", 32'(guard < 20), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", k),  32'(rsp_data),  32'h33);
      check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 32'(rsp_valid), 32'd0);
    check("bp_ready_back", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("bp_next_rd", 32'(mem_rd_en), 32'd1);
    check("bp_next_addr", 32'(mem_addr), 32'd9);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    exp_err++;
    check("bp_next_data", 32'(rsp_data), 32'h33);
    check("bp_next_corr", 32'(rsp_corr), 32'd1);
    check("bp_next_err", 32'(err_count), 32'(exp_err));
    @(posedge clk);

    // Reset pulsed during SCRUB
    preload(4'd4, 12'hC4A);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 4'd4; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_wr_en && guard < 20) begin @(negedge clk); guard++; end
    check("scrub_reached", 32'(mem_wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_scrub_wr", 32'(mem_wr_en), 32'd0);
    check("rst_scrub_valid", 32'(rsp_valid), 32'd0);
    check("rst_scrub_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("rst_scrub_no_rsp", 32'(saw_valid), 32'd0);
    check("rst_scrub_mem", 32'(mem[4]), 32'hC4A);

    // Saturation of the corrected-word counter
    for (int i = 0; i < 260; i++) begin
      preload(4'd6, 12'hC4A);
      do_read(4'd6, d, c, b, lat, wr, wa, wd);
      if (i == 253) check("sat_254", 32'(err_count), 32'd254);
      if (i == 254) check("sat_255", 32'(err_count), 32'd255);
    end
    check("sat_final", 32'(err_count), 32'd255);
    check("sat_last_corr", 32'(c), 32'd1);

    check("rd_wr_excl", 32'(collide), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
